// File: rtl/frv_mtimer_nch.sv
// frv_mtimer_nch: memory-mapped 64-bit machine timer with NCMP compare channels.
//
// Register window (word offsets from MMIO_BASE_ADDR):
//   0x00/0x04 mtime lo/hi, 0x08 prescale, 0x0C control (bit0 ten)
//   0x10+0x10*i cmp lo, 0x14+0x10*i cmp hi, 0x18+0x10*i period,
//   0x1C+0x10*i channel control {pending(W1C), periodic, ie}
//
// Bus handshake: an access is presented for exactly one cycle with mmio_en=1
// (no wait states, a new access may follow every cycle). Writes land on the
// edge that ends the mmio_en cycle; mmio_rdata/mmio_error are registered and
// valid for exactly the one cycle after mmio_en, zero otherwise. Out-of-window
// accesses are silently ignored; in-window misaligned or unmapped accesses
// report mmio_error and change nothing.
module frv_mtimer_nch #(
    parameter logic [31:0] MMIO_BASE_ADDR = 32'h0000_1000,
    parameter logic [31:0] MMIO_BASE_MASK = 32'hFFFF_F000,
    parameter int          NCMP           = 4,
    parameter int          PRESCALE_W     = 8
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            inhibit_tm,
    input  logic            mmio_en,
    input  logic            mmio_wen,
    input  logic [31:0]     mmio_addr,
    input  logic [31:0]     mmio_wdata,
    output logic [31:0]     mmio_rdata,
    output logic            mmio_error,
    output logic [63:0]     ctr_time,
    output logic [NCMP-1:0] irq,
    output logic            irq_any
);

    localparam logic [PRESCALE_W-1:0] PCNT_ONE = PRESCALE_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [63:0]           r_mtime;
    logic [PRESCALE_W-1:0] r_pcnt;
    logic [PRESCALE_W-1:0] r_prescale;
    logic                  r_ten;
    logic [63:0]           r_cmp     [NCMP];
    logic [31:0]           r_period  [NCMP];
    logic [NCMP-1:0]       r_ie;
    logic [NCMP-1:0]       r_periodic;
    logic [NCMP-1:0]       r_pending;
    logic [31:0]           r_rdata;
    logic                  r_error;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [31:0]     w_off;
    logic            w_in_win;
    logic            w_aligned;
    logic [27:0]     w_grp;
    logic [1:0]      w_reg;
    logic            w_glb;
    logic [NCMP-1:0] w_ch_sel;
    logic            w_mapped;
    logic            w_acc_ok;
    logic            w_acc_err;
    logic            w_wr;

    // Offset inside the window; group 0 holds the global registers, group
    // i+1 holds channel i, and the low word index selects the register.
    assign w_off     = mmio_addr & ~MMIO_BASE_MASK;
    assign w_in_win  = (mmio_addr & MMIO_BASE_MASK) == MMIO_BASE_ADDR;
    assign w_aligned = (w_off[1:0] == 2'b00);
    assign w_grp     = w_off[31:4];
    assign w_reg     = w_off[3:2];
    assign w_glb     = (w_grp == 28'd0);
    assign w_mapped  = w_glb | (|w_ch_sel);
    assign w_acc_ok  = mmio_en & w_in_win & w_aligned & w_mapped;
    assign w_acc_err = mmio_en & w_in_win & ~(w_aligned & w_mapped);
    assign w_wr      = w_acc_ok & mmio_wen;

    // Global register write strobes
    logic w_wr_mtlo;
    logic w_wr_mthi;
    logic w_wr_pre;
    logic w_wr_ctl;

    assign w_wr_mtlo = w_wr & w_glb & (w_reg == 2'd0);
    assign w_wr_mthi = w_wr & w_glb & (w_reg == 2'd1);
    assign w_wr_pre  = w_wr & w_glb & (w_reg == 2'd2);
    assign w_wr_ctl  = w_wr & w_glb & (w_reg == 2'd3);

    // Per-channel strobes and match / reload conditions
    logic [NCMP-1:0] w_wr_cmplo;
    logic [NCMP-1:0] w_wr_cmphi;
    logic [NCMP-1:0] w_wr_per;
    logic [NCMP-1:0] w_wr_chctl;
    logic [NCMP-1:0] w_match;
    logic [NCMP-1:0] w_clr;
    logic [NCMP-1:0] w_reload;

    for (genvar g = 0; g < NCMP; g++) begin : g_chdec
        assign w_ch_sel[g]   = (w_grp == 28'(g + 1));
        assign w_wr_cmplo[g] = w_wr & w_ch_sel[g] & (w_reg == 2'd0);
        assign w_wr_cmphi[g] = w_wr & w_ch_sel[g] & (w_reg == 2'd1);
        assign w_wr_per[g]   = w_wr & w_ch_sel[g] & (w_reg == 2'd2);
        assign w_wr_chctl[g] = w_wr & w_ch_sel[g] & (w_reg == 2'd3);
        assign w_match[g]    = (r_mtime >= r_cmp[g]);
        // Any cmp write also clears pending, so it shares the clear path.
        assign w_clr[g]      = w_wr_cmplo[g] | w_wr_cmphi[g]
                             | (w_wr_chctl[g] & mmio_wdata[2]);
        // Reload only on the edge that actually sets pending; a clear in the
        // same cycle defers it to the re-set on the following edge.
        assign w_reload[g]   = r_periodic[g] & (|r_period[g]) & w_match[g]
                             & ~r_pending[g] & ~w_clr[g];
    end

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic w_cnt_en;
    logic w_tick;

    assign w_cnt_en = r_ten & ~inhibit_tm;
    assign w_tick   = w_cnt_en & (r_pcnt == r_prescale);

    // Prescale counter: wraps to 0 on each tick, cleared by a prescale write.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_pcnt     <= '0;
            r_prescale <= '0;
            r_ten      <= 1'b1;
        end else begin
            if (w_wr_pre) begin
                r_pcnt <= '0;
            end else if (w_cnt_en) begin
                r_pcnt <= w_tick ? '0 : (r_pcnt + PCNT_ONE);
            end
            if (w_wr_pre) begin
                r_prescale <= mmio_wdata[PRESCALE_W-1:0];
            end
            if (w_wr_ctl) begin
                r_ten <= mmio_wdata[0];
            end
        end
    end

    // mtime: a bus write of either word wins over the tick increment.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_mtime <= '0;
        end else if (w_wr_mtlo || w_wr_mthi) begin
            if (w_wr_mtlo) begin
                r_mtime[31:0] <= mmio_wdata;
            end
            if (w_wr_mthi) begin
                r_mtime[63:32] <= mmio_wdata;
            end
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    // ------------------------------------------------------------------
    // Compare channels
    // ------------------------------------------------------------------
    // Channel registers: cmp writes beat reload, clear beats set of pending.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            for (int i = 0; i < NCMP; i++) begin
                r_cmp[i]    <= 64'hFFFF_FFFF_FFFF_FFFF;
                r_period[i] <= '0;
            end
            r_ie       <= '0;
            r_periodic <= '0;
            r_pending  <= '0;
        end else begin
            for (int i = 0; i < NCMP; i++) begin
                if (w_wr_cmplo[i] || w_wr_cmphi[i]) begin
                    if (w_wr_cmplo[i]) begin
                        r_cmp[i][31:0] <= mmio_wdata;
                    end
                    if (w_wr_cmphi[i]) begin
                        r_cmp[i][63:32] <= mmio_wdata;
                    end
                end else if (w_reload[i]) begin
                    r_cmp[i] <= r_cmp[i] + {32'd0, r_period[i]};
                end

                if (w_wr_per[i]) begin
                    r_period[i] <= mmio_wdata;
                end

                if (w_wr_chctl[i]) begin
                    r_ie[i]       <= mmio_wdata[0];
                    r_periodic[i] <= mmio_wdata[1];
                end

                if (w_clr[i]) begin
                    r_pending[i] <= 1'b0;
                end else if (w_match[i]) begin
                    r_pending[i] <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [31:0] w_rd_val;

    // Read mux over the current (pre-edge) register values.
    always_comb begin
        w_rd_val = '0;
        if (w_glb) begin
            case (w_reg)
                2'd0: w_rd_val = r_mtime[31:0];
                2'd1: w_rd_val = r_mtime[63:32];
                2'd2: w_rd_val = 32'(r_prescale);
                2'd3: w_rd_val = {31'd0, r_ten};
            endcase
        end
        for (int i = 0; i < NCMP; i++) begin
            if (w_ch_sel[i]) begin
                case (w_reg)
                    2'd0: w_rd_val = r_cmp[i][31:0];
                    2'd1: w_rd_val = r_cmp[i][63:32];
                    2'd2: w_rd_val = r_period[i];
                    2'd3: w_rd_val = {29'd0, r_pending[i], r_periodic[i], r_ie[i]};
                endcase
            end
        end
    end

    // Response register: one-cycle pulse of read data / error, else zero.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_rdata <= '0;
            r_error <= 1'b0;
        end else begin
            r_rdata <= (w_acc_ok && !mmio_wen) ? w_rd_val : 32'd0;
            r_error <= w_acc_err;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mmio_rdata = r_rdata;
    assign mmio_error = r_error;
    assign ctr_time   = r_mtime;
    assign irq        = r_pending & r_ie;
    assign irq_any    = |irq;

endmodule

// File: tb/tb_frv_mtimer_nch.sv
// tb_frv_mtimer_nch: directed table, multi-cycle sequences and a randomized
// run against a behavioural model of the timer's register-level rules.
module tb_frv_mtimer_nch;

    localparam int          NCMP = 4;
    localparam int          PW   = 8;
    localparam logic [31:0] BASE = 32'h0000_1000;

    // ------------------------------------------------------------------
    // Clock / reset and DUT
    // ------------------------------------------------------------------
    logic            clk;
    logic            rst;
    logic            inh;
    logic            en;
    logic            wen;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic [31:0]     rdata;
    logic            err;
    logic [63:0]     ctr_time;
    logic [NCMP-1:0] irq;
    logic            irq_any;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    frv_mtimer_nch #(
        .MMIO_BASE_ADDR (BASE),
        .MMIO_BASE_MASK (32'hFFFF_F000),
        .NCMP           (NCMP),
        .PRESCALE_W     (PW)
    ) dut (
        .g_clk      (clk),
        .g_reset    (rst),
        .inhibit_tm (inh),
        .mmio_en    (en),
        .mmio_wen   (wen),
        .mmio_addr  (addr),
        .mmio_wdata (wdata),
        .mmio_rdata (rdata),
        .mmio_error (err),
        .ctr_time   (ctr_time),
        .irq        (irq),
        .irq_any    (irq_any)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks (inputs change 1 time unit after the rising edge,
    // outputs are sampled at that same point)
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en    = 1'b0;
        wen   = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;
    endtask

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d);
        en    = 1'b1;
        wen   = w;
        addr  = a;
        wdata = d;
        step();
        idle();
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        access(1'b1, BASE + off, d);
    endtask

    task automatic do_reset();
        idle();
        inh = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_irq(input int ch, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (irq[ch]) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [63:0]     m_mtime;
    int unsigned     m_pcnt;
    logic [PW-1:0]   m_pre;
    logic            m_ten;
    logic [63:0]     m_cmp [NCMP];
    logic [31:0]     m_per [NCMP];
    logic [NCMP-1:0] m_ie;
    logic [NCMP-1:0] m_prd;
    logic [NCMP-1:0] m_pend;
    logic [31:0]     exp_rdata;
    logic            exp_err;

    task automatic model_reset();
        m_mtime = '0;
        m_pcnt  = 0;
        m_pre   = '0;
        m_ten   = 1'b1;
        for (int i = 0; i < NCMP; i++) begin
            m_cmp[i] = '1;
            m_per[i] = '0;
        end
        m_ie      = '0;
        m_prd     = '0;
        m_pend    = '0;
        exp_rdata = '0;
        exp_err   = 1'b0;
    endtask

    // Advance the model by one clock: natural timer/channel behaviour first,
    // then the bus write overlaid on top of it.
    task automatic model_step(input logic en_i, input logic wen_i, input logic [31:0] a,
                              input logic [31:0] d, input logic inh_i);
        logic [31:0]     off;
        logic            in_win;
        logic            ok;
        int              ch;
        int              rg;
        logic [31:0]     rv;
        logic            tick;
        int unsigned     n_pcnt;
        logic [63:0]     n_mtime;
        logic [63:0]     n_cmp [NCMP];
        logic [NCMP-1:0] n_pend;

        in_win = ((a & 32'hFFFF_F000) == BASE);
        off    = a & 32'h0000_0FFF;
        ok     = en_i && in_win && (off % 4 == 0) && (off < 32'(16 + 16 * NCMP));
        ch     = int'(off / 16) - 1;
        rg     = int'(off % 16) / 4;

        rv = 32'd0;
        if (ok) begin
            if (ch < 0) begin
                case (rg)
                    0: rv = m_mtime[31:0];
                    1: rv = m_mtime[63:32];
                    2: rv = 32'(m_pre);
                    default: rv = 32'(m_ten);
                endcase
            end else begin
                case (rg)
                    0: rv = m_cmp[ch][31:0];
                    1: rv = m_cmp[ch][63:32];
                    2: rv = m_per[ch];
                    default: rv = {29'd0, m_pend[ch], m_prd[ch], m_ie[ch]};
                endcase
            end
        end
        exp_rdata = (ok && !wen_i) ? rv : 32'd0;
        exp_err   = en_i && in_win && !ok;

        tick    = m_ten && !inh_i && (m_pcnt == 32'(m_pre));
        n_pcnt  = m_pcnt;
        if (m_ten && !inh_i) n_pcnt = tick ? 0 : m_pcnt + 1;
        n_mtime = tick ? m_mtime + 64'd1 : m_mtime;

        for (int i = 0; i < NCMP; i++) begin
            n_cmp[i]  = m_cmp[i];
            n_pend[i] = m_pend[i];
            if (m_mtime >= m_cmp[i]) begin
                n_pend[i] = 1'b1;
                if (!m_pend[i] && m_prd[i] && m_per[i] != 0)
                    n_cmp[i] = m_cmp[i] + {32'd0, m_per[i]};
            end
        end

        if (ok && wen_i) begin
            if (ch < 0) begin
                case (rg)
                    0: n_mtime = {m_mtime[63:32], d};
                    1: n_mtime = {d, m_mtime[31:0]};
                    2: begin m_pre = d[PW-1:0]; n_pcnt = 0; end
                    default: m_ten = d[0];
                endcase
            end else begin
                case (rg)
                    0: begin n_cmp[ch] = {m_cmp[ch][63:32], d}; n_pend[ch] = 1'b0; end
                    1: begin n_cmp[ch] = {d, m_cmp[ch][31:0]}; n_pend[ch] = 1'b0; end
                    2: m_per[ch] = d;
                    default: begin
                        m_ie[ch]  = d[0];
                        m_prd[ch] = d[1];
                        if (d[2]) begin
                            n_pend[ch] = 1'b0;
                            n_cmp[ch]  = m_cmp[ch];
                        end
                    end
                endcase
            end
        end

        m_pcnt  = n_pcnt;
        m_mtime = n_mtime;
        for (int i = 0; i < NCMP; i++) m_cmp[i] = n_cmp[i];
        m_pend = n_pend;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    task automatic fill_table();
        tbl.push_back('{1'b1, 32'h0000_100C, 32'h0000_0000, 32'h0000_0000, 1'b0}); // ten=0
        tbl.push_back('{1'b1, 32'h0000_1000, 32'h0000_1234, 32'h0000_0000, 1'b0});
        tbl.push_back('{1'b1, 32'h0000_1004, 32'h0000_0000, 32'h0000_0000, 1'b0});
        tbl.push_back('{1'b0, 32'h0000_1000, 32'h0000_0000, 32'h0000_1234, 1'b0});
        tbl.push_back('{1'b0, 32'h0000_100C, 32'h0000_0000, 32'h0000_0000, 1'b0});
        tbl.push_back('{1'b1, 32'h0000_1008, 32'hFFFF_FF05, 32'h0000_0000, 1'b0});
        tbl.push_back('{1'b0, 32'h0000_1008, 32'h0000_0000, 32'h0000_0005, 1'b0});
        tbl.push_back('{1'b1, 32'h0000_1018, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0});
        tbl.push_back('{1'b0, 32'h0000_1018, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0});
        tbl.push_back('{1'b1, 32'h0000_101C, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0});
        tbl.push_back('{1'b0, 32'h0000_101C, 32'h0000_0000, 32'h0000_0003, 1'b0});
        tbl.push_back('{1'b0, 32'h0000_1024, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0});
        tbl.push_back('{1'b0, 32'h0000_1002, 32'h0000_0000, 32'h0000_0000, 1'b1});
        tbl.push_back('{1'b1, 32'h0000_1001, 32'h0000_0005, 32'h0000_0000, 1'b1});
        tbl.push_back('{1'b0, 32'h0000_1000, 32'h0000_0000, 32'h0000_1234, 1'b0});
        tbl.push_back('{1'b0, 32'h0000_1050, 32'h0000_0000, 32'h0000_0000, 1'b1});
        tbl.push_back('{1'b1, 32'h0000_105C, 32'h0000_0001, 32'h0000_0000, 1'b1});
        tbl.push_back('{1'b0, 32'h0000_104C, 32'h0000_0000, 32'h0000_0000, 1'b0});
        tbl.push_back('{1'b0, 32'h0000_2000, 32'h0000_0000, 32'h0000_0000, 1'b0});
        tbl.push_back('{1'b1, 32'h0000_2000, 32'h0000_0007, 32'h0000_0000, 1'b0});
        tbl.push_back('{1'b0, 32'h0000_1FFC, 32'h0000_0000, 32'h0000_0000, 1'b1});
        tbl.push_back('{1'b0, 32'h0000_0FFC, 32'h0000_0000, 32'h0000_0000, 1'b0});
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        bit          ok;
        logic [31:0] off;
        logic [31:0] d;
        int          sel;

        idle();
        inh = 1'b0;
        rst = 1'b1;
        step();
        step();
        check("rst_rdata", rdata, 0);
        check("rst_error", err, 0);
        check("rst_time", ctr_time, 0);
        check("rst_irq", irq, 0);
        check("rst_irq_any", irq_any, 0);

        // Back-to-back reads straight out of reset
        rst   = 1'b0;
        en    = 1'b1;
        wen   = 1'b0;
        addr  = BASE + 32'h00;
        step();
        check("rd0_mtime", rdata, 32'h0);
        check("rd0_err", err, 0);
        addr = BASE + 32'h0C;
        step();
        check("rd1_ctl", rdata, 32'h1);
        check("rd1_err", err, 0);
        addr = BASE + 32'h10;
        step();
        check("rd2_cmp", rdata, 32'hFFFF_FFFF);
        check("rd2_err", err, 0);
        idle();
        step();
        check("rd_drop", rdata, 32'h0);

        // Table of single accesses
        do_reset();
        fill_table();
        foreach (tbl[i]) begin
            access(tbl[i].wen, tbl[i].addr, tbl[i].wdata);
            check($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rdata);
            check($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
        end

        // Prescaler and inhibit
        do_reset();
        wr(32'h08, 32'd3);
        check("pre_start", ctr_time, 64'd1);
        repeat (40) step();
        check("pre_40cyc", ctr_time, 64'd11);
        inh = 1'b1;
        repeat (20) step();
        check("pre_inhibit", ctr_time, 64'd11);
        inh = 1'b0;

        // One-shot channel 0
        do_reset();
        wr(32'h10, 32'd50);
        wr(32'h14, 32'd0);
        wr(32'h1C, 32'd1);
        wait_irq(0, ok);
        check("os_irq_seen", ok, 1);
        check("os_irq_time", ctr_time, 64'd51);
        repeat (5) step();
        check("os_irq_hold", irq[0], 1);
        wr(32'h1C, 32'd5);
        check("os_w1c_low", irq[0], 0);
        step();
        check("os_w1c_reset", irq[0], 1);
        wr(32'h14, 32'd1);
        check("os_cmphi_drop", irq[0], 0);
        repeat (10) step();
        check("os_cmphi_stay", irq[0], 0);

        // Periodic channel 1
        do_reset();
        wr(32'h20, 32'd20);
        wr(32'h24, 32'd0);
        wr(32'h28, 32'd10);
        wr(32'h2C, 32'd3);
        for (int k = 0; k < 3; k++) begin
            wait_irq(1, ok);
            check($sformatf("per%0d_seen", k), ok, 1);
            check($sformatf("per%0d_time", k), ctr_time, 64'(21 + 10 * k));
            wr(32'h2C, 32'd7);
        end
        access(1'b0, BASE + 32'h20, 32'd0);
        check("per_cmp_lo", rdata, 32'd50);
        access(1'b0, BASE + 32'h24, 32'd0);
        check("per_cmp_hi", rdata, 32'd0);

        // mtime wrap with channel 2 at cmp = 0
        do_reset();
        wr(32'h0C, 32'd0);
        wr(32'h00, 32'hFFFF_FFFE);
        wr(32'h04, 32'hFFFF_FFFF);
        wr(32'h30, 32'd0);
        wr(32'h34, 32'd0);
        wr(32'h0C, 32'd1);
        check("wrap_load", ctr_time, 64'hFFFF_FFFF_FFFF_FFFE);
        step();
        check("wrap_max", ctr_time, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        check("wrap_zero", ctr_time, 64'd0);
        wr(32'h3C, 32'd4);
        step();
        access(1'b0, BASE + 32'h3C, 32'd0);
        check("wrap_pending", rdata, 32'd4);
        check("wrap_no_irq", irq, 0);

        // Write to mtime on a tick cycle
        do_reset();
        wr(32'h00, 32'd100);
        check("col_mtlo", ctr_time, 64'd100);
        step();
        check("col_next", ctr_time, 64'd101);
        wr(32'h04, 32'd2);
        check("col_mthi", ctr_time, 64'h0000_0002_0000_0065);

        // Randomized run against the model
        do_reset();
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            sel = $urandom_range(0, 19);
            if (sel < 16)       off = 32'($urandom_range(0, 4 + 4 * NCMP - 1)) * 4;
            else if (sel == 16) off = 32'($urandom_range(0, 79) * 4 + $urandom_range(1, 3));
            else if (sel == 17) off = 32'(16 + 16 * NCMP + $urandom_range(0, 3) * 4);
            else if (sel == 18) off = 32'h1000 + 32'($urandom_range(0, 19) * 4);
            else                off = 32'($urandom_range(0, 4095));
            d = $urandom;
            if (off < 32'h10) begin
                case (off)
                    32'h00: d = 32'($urandom_range(0, 100));
                    32'h04: d = 32'd0;
                    32'h08: d = 32'($urandom_range(0, 3));
                    32'h0C: d = ($urandom_range(0, 4) != 0) ? 32'd1 : 32'd0;
                    default: ;
                endcase
            end else if (off < 32'(16 + 16 * NCMP)) begin
                case (off % 16)
                    32'h0: d = m_mtime[31:0] + 32'($urandom_range(0, 40));
                    32'h4: d = m_mtime[63:32];
                    32'h8: d = 32'($urandom_range(0, 15));
                    32'hC: d = 32'($urandom_range(0, 7));
                    default: ;
                endcase
            end
            en    = ($urandom_range(0, 2) != 0);
            wen   = $urandom_range(0, 1) == 1;
            addr  = BASE + off;
            wdata = d;
            inh   = ($urandom_range(0, 9) == 0);
            model_step(en, wen, addr, wdata, inh);
            step();
            check("rnd_rdata", rdata, exp_rdata);
            check("rnd_err", err, exp_err);
            check("rnd_time", ctr_time, m_mtime);
            check("rnd_irq", irq, m_pend & m_ie);
            check("rnd_irq_any", irq_any, |(m_pend & m_ie));
        end
        idle();
        inh = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Absolute time bound on the whole run
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/frv_mtimer_nch.md
# frv_mtimer_nch

Parametrised successor to the core's timer/counter block: a memory-mapped 64-bit machine timer with `NCMP` independent compare channels. Each channel can run one-shot or auto-reload (periodic), and the timer has a programmable prescaler. It sits beside the pipeline on the existing MMIO port. It feeds `ctr_time` to the CSR file and per-channel interrupt lines to the interrupt block; channel 0 replaces the legacy `mtimecmp` timer interrupt.

## Interface
Parameters:
- `MMIO_BASE_ADDR`, default 32'h0000_1000: base of the register window.
- `MMIO_BASE_MASK`, default 32'hFFFF_F000: window match mask.
- `NCMP`, default 4: number of compare channels, legal range 1..8.
- `PRESCALE_W`, default 8: width of the prescale register.

Ports:
- `g_clk`, in, 1: the single clock.
- `g_reset`, in, 1: reset, asynchronous and active-high.
- `inhibit_tm`, in, 1: freezes the prescaler and `mtime`.
- `mmio_en`, in, 1: access strobe.
- `mmio_wen`, in, 1: write enable.
- `mmio_addr`, in, 32: byte address.
- `mmio_wdata`, in, 32: write data.
- `mmio_rdata`, out, 32: registered read data.
- `mmio_error`, out, 1: registered access error.
- `ctr_time`, out, 64: current `mtime`.
- `irq`, out, NCMP: per-channel interrupt, equal to `pending[i] & ie[i]`.
- `irq_any`, out, 1: OR of `irq`.

## Operation
Register map (word offsets from `MMIO_BASE_ADDR`):
- 0x00 / 0x04: `mtime` low / high word.
- 0x08: `prescale`, bits [PRESCALE_W-1:0]; upper bits read 0.
- 0x0C: global control. Bit0 `ten` (timer enable); other bits read 0.
- 0x10+0x10·i: channel i `cmp` low word.
- 0x14+0x10·i: channel i `cmp` high word.
- 0x18+0x10·i: channel i `period` (32-bit).
- 0x1C+0x10·i: channel i control.
  - Bit0 `ie`.
  - Bit1 `periodic`.
  - Bit2 `pending`: read status; writing 1 clears it, writing 0 has no effect.

Access decode:
- An access is in-window when `(mmio_addr & MMIO_BASE_MASK) == MMIO_BASE_ADDR`.
- Out-of-window access: ignored; `mmio_rdata` = 0, `mmio_error` = 0.
- In-window access that is misaligned (`addr[1:0]` ≠ 0), or whose offset is beyond channel `NCMP-1` or otherwise unmapped:
  - `mmio_error` = 1, `mmio_rdata` = 0;
  - no state changes.

Prescaler and `mtime`:
- An internal counter `pcnt` counts while `ten` = 1 and `inhibit_tm` = 0.
- A tick is generated when `pcnt == prescale`; `pcnt` then returns to 0.
- `prescale` = 0 gives one tick every cycle.
- Writing `prescale` clears `pcnt`.
- On a tick, `mtime` increments by 1, modulo 2^64 (0xFFFF_FFFF_FFFF_FFFF wraps to 0).

Channel i:
- Match condition: `mtime >= cmp[i]`, 64-bit unsigned, evaluated every cycle on the registered values.
- On a match, `pending[i]` is set on the next edge. It stays set until cleared by writing 1 to bit2 or by a write to `cmp[i]` low or high. If the match still holds after a clear, `pending[i]` sets again on the following edge.
- Periodic mode: when `periodic` = 1 and `period` ≠ 0, the first match while `pending[i]` = 0 also reloads `cmp[i] <= cmp[i] + {32'b0, period[i]}`, modulo 2^64, on the same edge. This reload happens at most once per set of `pending`.
- `period` = 0 behaves exactly as one-shot.

Priority rules:
- An MMIO write to `mtime` beats the increment in the same cycle: the written word is loaded, the other word is kept, and there is no increment.
- An MMIO write to `cmp` beats a periodic reload in the same cycle.
- A set of `pending` and a W1C of `pending` in the same cycle: the clear wins for that cycle; re-set follows on the next edge if the match still holds.

## Timing
- Reset values (asynchronous):
  - `mtime`, `pcnt`, `prescale` = 0.
  - `ten` = 1.
  - Every `cmp` = 64'hFFFF_FFFF_FFFF_FFFF.
  - Every `period`, `ie`, `periodic`, `pending` = 0.
  - Outputs: `irq` = 0, `irq_any` = 0, `mmio_rdata` = 0, `mmio_error` = 0, `ctr_time` = 0.
- Reads: `mmio_rdata` and `mmio_error` are valid exactly 1 cycle after the `mmio_en` cycle. They hold for one cycle, then return to 0.
- There is no wait state; a new access may be issued every cycle.
- Writes take effect at the edge that ends the `mmio_en` cycle.
- `ctr_time` is the `mtime` register directly, with zero latency.
- Match-to-interrupt latency: `irq[i]` rises 1 cycle after the cycle in which `mtime >= cmp[i]` first holds with `ie[i]` = 1.
- Reset asserted mid-operation clears all state immediately. Accesses in flight are dropped; no response is produced.

## Test plan
- Reset, then read 0x00, 0x0C and 0x10: responses arrive 1 cycle later, in order 0, 1 and 0xFFFF_FFFF, all with `mmio_error` = 0.
- Prescale: write `prescale` = 3, then run 40 cycles → `mtime` advances by 10. Then hold `inhibit_tm` = 1 for 20 cycles → `mtime` is unchanged.
- One-shot:
  - Set ch0 `cmp` = 50 and `ie` = 1 → `irq[0]` rises one cycle after `mtime` = 50 and stays high.
  - W1C bit2 → `irq[0]` re-asserts on the next edge.
  - Write `cmp` hi = 1 → `irq[0]` drops and stays 0.
- Periodic:
  - Set ch1 `cmp` = 20, `period` = 10, `periodic` = 1, `ie` = 1, and clear pending after each assertion → `irq[1]` sets at `mtime` 20, 30, 40.
  - Read back `cmp` → 50 after the third reload.
- Wrap: write `mtime` = 0xFFFF_FFFF_FFFF_FFFE with `prescale` = 0 → after 2 ticks `ctr_time` = 0, and a channel with `cmp` = 0 asserts pending.
- Errors and collisions:
  - Access `addr` 0x1002 → `mmio_error` = 1.
  - Access offset 0x10+0x10·`NCMP` → `mmio_error` = 1.
  - Access 0x2000 → `mmio_error` = 0.
  - Write `mtime` lo on a tick cycle → the written value is kept with no increment.
